traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_pkg.sv | 50 +++++
 rtl/phase_timer.sv | 29 ++
 rtl/traffic_phase_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler: phase encoding,
// default timing constants and the lamp decode used by the top level.
package traffic_pkg;

   // Phase encoding as seen on the phase output port.
   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR1  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR2  = 3'd5
   } phase_e;

   // Default durations in clock cycles.
   localparam int GREEN_T_DEF  = 15;
   localparam int YELLOW_T_DEF = 3;
   localparam int ALLRED_T_DEF = 3;
   localparam int EXT_T_DEF    = 5;
   localparam int MAX_EXT_DEF  = 2;
   localparam int WALK_T_DEF   = 8;

   typedef struct packed {
      logic ns_g;
      logic ns_y;
      logic ns_r;
      logic ew_g;
      logic ew_y;
      logic ew_r;
   } lamps_t;

   // Exactly one lamp per direction; unused codes fall back to all-red.
   function automatic lamps_t lamp_decode(input phase_e p);
      lamps_t l;
      l = '0;
      case (p)
         NS_G:    begin l.ns_g = 1'b1; l.ew_r = 1'b1; end
         NS_Y:    begin l.ns_y = 1'b1; l.ew_r = 1'b1; end
         EW_G:    begin l.ns_r = 1'b1; l.ew_g = 1'b1; end
         EW_Y:    begin l.ns_r = 1'b1; l.ew_y = 1'b1; end
         default: begin l.ns_r = 1'b1; l.ew_r = 1'b1; end
      endcase
      return l;
   endfunction

   function automatic logic is_green(input phase_e p);
      return (p == NS_G) || (p == EW_G);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 8-bit down-counter used to time every phase. Load wins over
// hold; the count stops at zero and never wraps.
module phase_timer #(
   parameter logic [7:0] RST_VAL = 8'd0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       hold,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] count;

   // Count down one step per cycle unless loaded, held or already at zero.
   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      if (rst)
         count <= RST_VAL;
      else if (load)
         count <= load_val;
      else if (!hold && count != 8'd0)
         count <= count - 8'd1;
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection controller: fixed phase cycle with green
// extension on demand, latched pedestrian walk requests and emergency
// preemption. All lamp, walk and status outputs are registered.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_T  = GREEN_T_DEF,
   parameter int YELLOW_T = YELLOW_T_DEF,
   parameter int ALLRED_T = ALLRED_T_DEF,
   parameter int EXT_T    = EXT_T_DEF,
   parameter int MAX_EXT  = MAX_EXT_DEF,
   parameter int WALK_T   = WALK_T_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_ns,
   input  logic       ped_ew,
   input  logic       emg_req,
   input  logic       emg_dir,
   output logic       ns_g,
   output logic       ns_y,
   output logic       ns_r,
   output logic       ew_g,
   output logic       ew_y,
   output logic       ew_r,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic       emg_active,
   output logic [2:0] phase
);

   // Timer reload values are duration-1 so a state lasts exactly its duration.
   localparam logic [7:0] GREEN_RL  = 8'(GREEN_T - 1);
   localparam logic [7:0] YELLOW_RL = 8'(YELLOW_T - 1);
   localparam logic [7:0] ALLRED_RL = 8'(ALLRED_T - 1);
   localparam logic [7:0] EXT_RL    = 8'(EXT_T - 1);
   localparam logic [7:0] WALK_L    = 8'(WALK_T);
   localparam logic [2:0] MAX_EXT_L = 3'(MAX_EXT);

   phase_e     state, nxt_state;
   logic       tmr_load, tmr_hold, tmr_zero;
   logic [7:0] tmr_val;
   logic       ext_inc;
   logic [2:0] ext_cnt;
   logic       pend_ns, pend_ew, pend_ns_n, pend_ew_n;
   logic       enter_ns, enter_ew;
   logic [7:0] wrem_ns, wrem_ew, wbase_ns, wbase_ew, wrem_ns_n, wrem_ew_n;
   logic       walk_ns_n, walk_ew_n;
   lamps_t     lamps_q;

   phase_timer #(.RST_VAL(GREEN_RL)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .hold     (tmr_hold),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Next-phase decision and timer control. Yellow only ever leads to
   // all-red, so a green can only be entered from AR1 or AR2.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      nxt_state = state;
      tmr_load  = 1'b0;
      tmr_hold  = 1'b0;
      tmr_val   = 8'd0;
      ext_inc   = 1'b0;
      case (state)
         NS_G: begin
            if (emg_req && !emg_dir) begin
               tmr_hold = 1'b1;
            end else if (emg_req) begin
               nxt_state = NS_Y;
               tmr_load  = 1'b1;
               tmr_val   = YELLOW_RL;
            end else if (tmr_zero) begin
               if (car_ns && !car_ew && !pend_ew && ext_cnt < MAX_EXT_L) begin
                  tmr_load = 1'b1;
                  tmr_val  = EXT_RL;
                  ext_inc  = 1'b1;
               end else begin
                  nxt_state = NS_Y;
                  tmr_load  = 1'b1;
                  tmr_val   = YELLOW_RL;
               end
            end
         end
         NS_Y: begin
            if (tmr_zero) begin
               nxt_state = AR1;
               tmr_load  = 1'b1;
               tmr_val   = ALLRED_RL;
            end
         end
         AR1: begin
            if (tmr_zero) begin
               nxt_state = (emg_req && !emg_dir) ? NS_G : EW_G;
               tmr_load  = 1'b1;
               tmr_val   = GREEN_RL;
            end
         end
         EW_G: begin
            if (emg_req && emg_dir) begin
               tmr_hold = 1'b1;
            end else if (emg_req) begin
               nxt_state = EW_Y;
               tmr_load  = 1'b1;
               tmr_val   = YELLOW_RL;
            end else if (tmr_zero) begin
               if (car_ew && !car_ns && !pend_ns && ext_cnt < MAX_EXT_L) begin
                  tmr_load = 1'b1;
                  tmr_val  = EXT_RL;
                  ext_inc  = 1'b1;
               end else begin
                  nxt_state = EW_Y;
                  tmr_load  = 1'b1;
                  tmr_val   = YELLOW_RL;
               end
            end
         end
         EW_Y: begin
            if (tmr_zero) begin
               nxt_state = AR2;
               tmr_load  = 1'b1;
               tmr_val   = ALLRED_RL;
            end
         end
         AR2: begin
            if (tmr_zero) begin
               nxt_state = (emg_req && emg_dir) ? EW_G : NS_G;
               tmr_load  = 1'b1;
               tmr_val   = GREEN_RL;
            end
         end
         default: begin
            nxt_state = AR2;
            tmr_load  = 1'b1;
            tmr_val   = ALLRED_RL;
         end
      endcase
   end

   // Pedestrian bookkeeping: a request pending at green entry grants
   // WALK_T walk cycles; walk cycles are not spent while preempted.
   always_comb begin
      enter_ns  = (nxt_state == NS_G) && (state != NS_G);
      enter_ew  = (nxt_state == EW_G) && (state != EW_G);
      pend_ns_n = enter_ns ? ped_ns : (pend_ns | ped_ns);
      pend_ew_n = enter_ew ? ped_ew : (pend_ew | ped_ew);
      wbase_ns  = enter_ns ? (pend_ns ? WALK_L : 8'd0) : wrem_ns;
      wbase_ew  = enter_ew ? (pend_ew ? WALK_L : 8'd0) : wrem_ew;
      walk_ns_n = (nxt_state == NS_G) && !emg_req && (wbase_ns != 8'd0);
      walk_ew_n = (nxt_state == EW_G) && !emg_req && (wbase_ew != 8'd0);
      wrem_ns_n = (nxt_state != NS_G) ? 8'd0 : (walk_ns_n ? wbase_ns - 8'd1 : wbase_ns);
      wrem_ew_n = (nxt_state != EW_G) ? 8'd0 : (walk_ew_n ? wbase_ew - 8'd1 : wbase_ew);
   end

   // Phase register plus registered outputs decoded from the next phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= NS_G;
         ext_cnt    <= 3'd0;
         pend_ns    <= 1'b0;
         pend_ew    <= 1'b0;
         wrem_ns    <= 8'd0;
         wrem_ew    <= 8'd0;
         walk_ns    <= 1'b0;
         walk_ew    <= 1'b0;
         emg_active <= 1'b0;
         lamps_q    <= lamp_decode(NS_G);
      end else begin
         state      <= nxt_state;
         if (enter_ns || enter_ew)
            ext_cnt <= 3'd0;
         else if (ext_inc)
            ext_cnt <= ext_cnt + 3'd1;
         pend_ns    <= pend_ns_n;
         pend_ew    <= pend_ew_n;
         wrem_ns    <= wrem_ns_n;
         wrem_ew    <= wrem_ew_n;
         walk_ns    <= walk_ns_n;
         walk_ew    <= walk_ew_n;
         emg_active <= emg_req && is_green(nxt_state);
         lamps_q    <= lamp_decode(nxt_state);
      end
   end

   assign ns_g  = lamps_q.ns_g;
   assign ns_y  = lamps_q.ns_y;
   assign ns_r  = lamps_q.ns_r;
   assign ew_g  = lamps_q.ew_g;
   assign ew_y  = lamps_q.ew_y;
   assign ew_r  = lamps_q.ew_r;
   assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a behavioural model
// (elapsed-cycles vs. phase budget) predicts every output cycle, a
// monitor compares, and directed scenarios check phase/walk durations.
module tb_traffic_phase_scheduler;

   localparam int GREEN_T  = 15;
   localparam int YELLOW_T = 3;
   localparam int ALLRED_T = 3;
   localparam int EXT_T    = 5;
   localparam int MAX_EXT  = 2;
   localparam int WALK_T   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic car_ns = 1'b0, car_ew = 1'b0, ped_ns = 1'b0, ped_ew = 1'b0;
   logic emg_req = 1'b0, emg_dir = 1'b0;
   logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew, emg_active;
   logic [2:0] phase;

   traffic_phase_scheduler #(
      .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
      .EXT_T(EXT_T), .MAX_EXT(MAX_EXT), .WALK_T(WALK_T)
   ) dut (
      .clk(clk), .rst(rst), .car_ns(car_ns), .car_ew(car_ew),
      .ped_ns(ped_ns), .ped_ew(ped_ew), .emg_req(emg_req), .emg_dir(emg_dir),
      .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
      .walk_ns(walk_ns), .walk_ew(walk_ew), .emg_active(emg_active), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] ph;
      logic [5:0] lamps;   // ns_g ns_y ns_r ew_g ew_y ew_r
      logic       wns;
      logic       wew;
      logic       emg;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   sb_on  = 1'b0;

   // Reference model state: phase number, counting cycles elapsed and budget.
   int   m_phase, m_elapsed, m_budget, m_ext;
   bit   m_pend[2];
   int   m_wleft[2];

   // Run recorder fed by the monitor from DUT outputs.
   int   runs_ph[$];
   int   runs_len[$];
   int   run_ph, run_len;
   int   walk_ew_cnt, walk_ew_rises, walk_rise_ph, walk_rise_len, emg_cnt;
   logic walk_ew_q = 1'b0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int dur(input int p);
      case (p)
         0, 3:    return GREEN_T;
         1, 4:    return YELLOW_T;
         default: return ALLRED_T;
      endcase
   endfunction

   function automatic logic [5:0] lamps_for(input int p);
      case (p)
         0:       return 6'b100_001;
         1:       return 6'b010_001;
         3:       return 6'b001_100;
         4:       return 6'b001_010;
         default: return 6'b001_001;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs now driven.
   task automatic model_step();
      obs_t e;
      int   np, gd;
      bit   adv, g, own, opp, ped, walk[2];
      walk = '{1'b0, 1'b0};
      if (rst) begin
         m_phase = 0; m_elapsed = 0; m_budget = GREEN_T; m_ext = 0;
         m_pend = '{1'b0, 1'b0}; m_wleft = '{0, 0};
         e.emg = 1'b0;
      end else begin
         g   = (m_phase == 0) || (m_phase == 3);
         gd  = (m_phase == 3) ? 1 : 0;
         own = gd ? car_ew : car_ns;
         opp = gd ? car_ns : car_ew;
         np  = m_phase;
         adv = 1'b1;
         if (g && emg_req) begin
            if (int'(emg_dir) == gd) adv = 1'b0;
            else np = m_phase + 1;
         end else if (m_elapsed == m_budget - 1) begin
            if (g && own && !opp && !m_pend[1 - gd] && m_ext < MAX_EXT) begin
               m_budget += EXT_T;
               m_ext++;
            end else if (m_phase == 2 || m_phase == 5) begin
               np = emg_req ? (emg_dir ? 3 : 0) : ((m_phase == 2) ? 3 : 0);
            end else begin
               np = m_phase + 1;
            end
         end
         if (np != m_phase) begin
            m_elapsed = 0; m_budget = dur(np); m_ext = 0;
         end else if (adv) begin
            m_elapsed++;
         end
         for (int d = 0; d < 2; d++) begin
            int gp;
            gp  = d ? 3 : 0;
            ped = d ? ped_ew : ped_ns;
            if (np == gp && m_phase != gp) begin
               m_wleft[d] = m_pend[d] ? WALK_T : 0;
               m_pend[d]  = ped;
            end else begin
               m_pend[d] = m_pend[d] | ped;
            end
            if (np != gp) m_wleft[d] = 0;
            walk[d] = (np == gp) && !emg_req && (m_wleft[d] > 0);
            if (walk[d]) m_wleft[d]--;
         end
         m_phase = np;
         e.emg = emg_req && (np == 0 || np == 3);
      end
      e.ph    = 3'(m_phase);
      e.lamps = lamps_for(m_phase);
      e.wns   = walk[0];
      e.wew   = walk[1];
      exp_q.push_back(e);
      sb_on = 1'b1;
   endtask

   task automatic cyc(input bit r, input bit cn, input bit ce, input bit pn,
                      input bit pe, input bit er, input bit ed);
      @(negedge clk);
      rst = r; car_ns = cn; car_ew = ce; ped_ns = pn; ped_ew = pe;
      emg_req = er; emg_dir = ed;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_rec();
      runs_ph.delete();
      runs_len.delete();
      walk_ew_cnt = 0; walk_ew_rises = 0; walk_rise_ph = -1; walk_rise_len = -1;
      emg_cnt = 0;
   endtask

   task automatic check_run(input string name, input int idx, input int ph, input int len);
      if (idx >= runs_ph.size()) begin
         check({name, "_present"}, runs_ph.size(), idx + 1);
      end else begin
         check({name, "_phase"}, runs_ph[idx], ph);
         check({name, "_len"}, runs_len[idx], len);
      end
   endtask

   // Monitor: compare every DUT output cycle with the scoreboard head.
   initial begin
      obs_t act, e;
      forever begin
         @(posedge clk);
         #1;
         if (!sb_on) continue;
         act = {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk_ns, walk_ew, emg_active};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard @%0t: output with no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL outputs @%0t: got ph=%0d lamps=%b wns=%b wew=%b emg=%b, expected ph=%0d lamps=%b wns=%b wew=%b emg=%b",
                        $time, act.ph, act.lamps, act.wns, act.wew, act.emg,
                        e.ph, e.lamps, e.wns, e.wew, e.emg);
            end
         end
         if (rst) begin
            run_ph = int'(phase); run_len = 1;
         end else if (int'(phase) == run_ph) begin
            run_len++;
         end else begin
            runs_ph.push_back(run_ph); runs_len.push_back(run_len);
            run_ph = int'(phase); run_len = 1;
         end
         if (walk_ew) walk_ew_cnt++;
         if (walk_ew && !walk_ew_q) begin
            walk_ew_rises++; walk_rise_ph = int'(phase); walk_rise_len = run_len;
         end
         walk_ew_q = walk_ew;
         if (emg_active) emg_cnt++;
      end
   end

   initial begin
      int exp_ph[6]  = '{0, 1, 2, 3, 4, 5};
      int exp_len[6] = '{15, 3, 3, 15, 3, 3};
      int sum, n;
      bit cn, ce, er, ed;
      int emg_left;

      // Idle cycle: 15/3/3/15/3/3, 42-cycle period.
      clear_rec();
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(90);
      settle();
      sum = 0;
      for (int i = 0; i < 12; i++) begin
         check_run($sformatf("idle_run%0d", i), i, exp_ph[i % 6], exp_len[i % 6]);
         if (i < 6 && i < runs_len.size()) sum += runs_len[i];
      end
      check("idle_period", sum, 42);

      // NS demand only: two extensions, 15+5+5.
      clear_rec();
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 0, 0);
      settle();
      check_run("ext_nsg", 0, 0, 25);
      check_run("ext_nsy", 1, 1, 3);

      // EW walk request during NS_G: 8 walk cycles from EW_G entry, then cleared.
      clear_rec();
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(3);
      cyc(0, 0, 0, 0, 1, 0, 0);
      idle(90);
      settle();
      check("walk_ew_cycles", walk_ew_cnt, WALK_T);
      check("walk_ew_rises", walk_ew_rises, 1);
      check("walk_ew_rise_phase", walk_rise_ph, 3);
      check("walk_ew_rise_at_entry", walk_rise_len, 1);

      // EW preemption at NS_G cycle 5: yellow, all-red, EW_G held, resume.
      clear_rec();
      cyc(1, 0, 0, 0, 0, 0, 0);
      idle(4);
      for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 0, 1, 1);
      idle(30);
      settle();
      check_run("emg_nsg", 0, 0, 5);
      check_run("emg_nsy", 1, 1, YELLOW_T);
      check_run("emg_ar1", 2, 2, ALLRED_T);
      // 24 held cycles showing GREEN_T-1, then GREEN_T-1 more countdown cycles.
      check_run("emg_ewg", 3, 3, 24 + GREEN_T - 1);
      check("emg_active_cycles", emg_cnt, 24);

      // NS preemption from AR2 cycle 1: AR2 completes, NS_G held then expires.
      cyc(1, 0, 0, 0, 0, 0, 0);
      n = 0;
      while (m_phase != 5 && n < 100) begin idle(1); n++; end
      settle();
      check("reach_ar2", int'(phase), 5);
      clear_rec();
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, 0);
      idle(20);
      settle();
      check_run("ar2_emg_ar2", 0, 5, ALLRED_T);
      check_run("ar2_emg_nsg", 1, 0, 18 + GREEN_T - 1);
      check("ar2_emg_active", emg_cnt, 18);

      // Reset in the middle of EW_Y.
      n = 0;
      while (m_phase != 4 && n < 100) begin idle(1); n++; end
      settle();
      check("reach_ewy", int'(phase), 4);
      idle(1);
      clear_rec();
      cyc(1, 0, 0, 0, 0, 0, 0);
      settle();
      check("rst_ns_g", int'(ns_g), 1);
      check("rst_ew_r", int'(ew_r), 1);
      check("rst_phase", int'(phase), 0);
      idle(20);
      settle();
      check_run("rst_nsg", 0, 0, GREEN_T);

      // Randomised traffic, pedestrians, preemption bursts and resets.
      cn = 0; ce = 0; er = 0; ed = 0; emg_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) cn = ~cn;
         if ($urandom_range(7) == 0) ce = ~ce;
         if (emg_left > 0) begin
            emg_left--;
            er = (emg_left != 0);
         end else if ($urandom_range(149) == 0) begin
            emg_left = $urandom_range(40, 5);
            er = 1'b1;
            ed = 1'($urandom_range(1));
         end
         cyc(($urandom_range(499) == 0), cn, ce, ($urandom_range(24) == 0),
             ($urandom_range(24) == 0), er, ed);
      end
      idle(2);
      settle();
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
